// File: rtl/parity_frame_tx_if.sv
// parity_frame_tx_if: byte/parity handshake and serial-line signals of the frame transmitter.
interface parity_frame_tx_if;
  logic [7:0] din;
  logic       parity;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic       par_err;
  modport master (output din, parity, in_valid, input in_ready, tx, busy, frame_done, par_err);
  modport slave  (input din, parity, in_valid, output in_ready, tx, busy, frame_done, par_err);
endinterface

// File: rtl/parity_frame_tx.sv
// parity_frame_tx: LSB-first start/8 data/parity/stop serial transmitter; define PARITY_CHECK_EN for the par_err checker.
module parity_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input logic clk,
  input logic rst,
  parity_frame_tx_if.slave bus
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t        r_state, w_state;
  logic [TW-1:0] r_timer, w_timer;
  logic [2:0]    r_idx, w_idx;
  logic [7:0]    r_shift, w_shift;
  logic          r_par, w_par, r_tx, w_tx, w_wrap, w_accept;
  assign w_wrap = r_timer == TW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state;
      r_timer <= w_timer;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_par   <= w_par;
      r_tx    <= w_tx;
    end
  end
  always_comb begin
    w_state  = r_state;
    w_timer  = (r_state == IDLE || w_wrap) ? '0 : r_timer + 1'b1;
    w_idx    = r_idx;
    w_shift  = r_shift;
    w_par    = r_par;
    w_accept = r_state == IDLE && bus.in_valid;
    case (r_state)
      IDLE: if (w_accept) begin
        w_state = START;
        w_shift = bus.din;
        w_par   = bus.parity;
      end
      START: if (w_wrap) begin
        w_state = DATA;
        w_idx   = '0;
      end
      DATA: if (w_wrap) begin
        w_shift = r_shift >> 1;
        w_idx   = r_idx + 3'd1;
        if (r_idx == 3'd7) w_state = PARITY;
      end
      PARITY: if (w_wrap) w_state = STOP;
      STOP: if (w_wrap) w_state = IDLE;
      default: w_state = IDLE;
    endcase
    // tx is registered from the next state so the line never glitches
    w_tx = w_state == START ? 1'b0 : w_state == DATA ? w_shift[0] : w_state == PARITY ? r_par : 1'b1;
  end
  assign bus.tx         = r_tx;
  assign bus.in_ready   = r_state == IDLE;
  assign bus.busy       = r_state != IDLE;
  assign bus.frame_done = r_state == STOP && w_wrap;
`ifdef PARITY_CHECK_EN
  logic r_par_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_par_err <= 1'b0;
    else if (w_accept) r_par_err <= ^bus.din ^ bus.parity;
  end
  assign bus.par_err = r_par_err;
`else
  assign bus.par_err = 1'b0;
`endif
endmodule

// File: tb/tb_parity_frame_tx.sv
// tb_parity_frame_tx: table-driven frame checks plus back-to-back, stall and mid-frame reset sequences.
module tb_parity_frame_tx;
  localparam int C = 4;
`ifdef PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif
  typedef struct {
    logic [7:0]  din;
    logic        par;
    logic [10:0] frame;
    logic        mism;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vt [4];
  parity_frame_tx_if bus ();
  parity_frame_tx #(.CLKS_PER_BIT(C)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  task automatic offer(input logic [7:0] d, input logic p);
    bus.din      = d;
    bus.parity   = p;
    bus.in_valid = 1'b1;
  endtask
  task automatic chk_idle(input logic pe);
    chk("idle_tx", {15'd0, bus.tx}, 16'd1);
    chk("idle_in_ready", {15'd0, bus.in_ready}, 16'd1);
    chk("idle_busy", {15'd0, bus.busy}, 16'd0);
    chk("idle_frame_done", {15'd0, bus.frame_done}, 16'd0);
    chk("idle_par_err", {15'd0, bus.par_err}, {15'd0, pe});
  endtask
  // Called in cycle N+1 of a frame; returns in its last cycle N+11*C.
  task automatic run_frame(input logic [10:0] f, input logic pe);
    for (int c = 1; c <= 11 * C; c++) begin
      chk("tx", {15'd0, bus.tx}, {15'd0, f[(c - 1) / C]});
      chk("frame_done", {15'd0, bus.frame_done}, {15'd0, c == 11 * C});
      chk("busy", {15'd0, bus.busy}, 16'd1);
      chk("in_ready", {15'd0, bus.in_ready}, 16'd0);
      chk("par_err", {15'd0, bus.par_err}, {15'd0, pe});
      if (c < 11 * C) tick();
    end
  endtask
  initial begin
    vt[0] = '{8'hA5, 1'b0, 11'b1_0_10100101_0, 1'b0};
    vt[1] = '{8'h01, 1'b0, 11'b1_0_00000001_0, 1'b1};
    vt[2] = '{8'h03, 1'b0, 11'b1_0_00000011_0, 1'b0};
    vt[3] = '{8'h80, 1'b1, 11'b1_1_10000000_0, 1'b0};
    bus.din = 8'h00;
    bus.parity = 1'b0;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_idle(1'b0);
    for (int i = 0; i < 4; i++) begin
      offer(vt[i].din, vt[i].par);
      tick();
      bus.in_valid = 1'b0;
      bus.din = ~vt[i].din;
      run_frame(vt[i].frame, vt[i].mism & PCHK);
      tick();
      chk_idle(vt[i].mism & PCHK);
    end
    offer(8'h00, 1'b0);
    tick();
    bus.din = 8'hFF;
    run_frame(11'b1_0_00000000_0, 1'b0);
    tick();
    chk_idle(1'b0);
    tick();
    bus.in_valid = 1'b0;
    run_frame(11'b1_0_11111111_0, 1'b0);
    tick();
    chk_idle(1'b0);
    offer(8'hA5, 1'b0);
    tick();
    offer(8'h3C, 1'b0);
    run_frame(11'b1_0_10100101_0, 1'b0);
    tick();
    chk_idle(1'b0);
    tick();
    bus.in_valid = 1'b0;
    run_frame(11'b1_0_00111100_0, 1'b0);
    tick();
    chk_idle(1'b0);
    offer(8'hA5, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    repeat (17) tick();
    chk("pre_rst_tx", {15'd0, bus.tx}, 16'd0);
    chk("pre_rst_busy", {15'd0, bus.busy}, 16'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_tx", {15'd0, bus.tx}, 16'd1);
    chk("async_rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
    chk("async_rst_frame_done", {15'd0, bus.frame_done}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_frame_done", {15'd0, bus.frame_done}, 16'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 2 * C; i++) begin
      tick();
      chk_idle(1'b0);
    end
    offer(vt[1].din, vt[1].par);
    tick();
    bus.in_valid = 1'b0;
    run_frame(vt[1].frame, vt[1].mism & PCHK);
    tick();
    chk_idle(vt[1].mism & PCHK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/parity_frame_tx.md
# parity_frame_tx

Serial frame transmitter downstream of the 8-bit parity generator. It accepts a byte plus its even-parity bit over a valid/ready handshake and shifts out one frame, LSB first: start bit, 8 data bits, parity bit, stop bit. It is the output stage that turns parallel byte/parity pairs into a single-wire line.

## Interface
- CLKS_PER_BIT, 4: clock cycles per serial bit; legal range 2..65535.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  8  data byte; sampled on handshake.
- parity  input  1  even parity of din (XOR of all din bits); sampled on handshake.
- in_valid  input  1  din/parity are valid.
- in_ready  output  1  block can accept a byte; high only in IDLE.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in flight (any state except IDLE).
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.
- par_err  output  1  parity mismatch flag (see Configuration).

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake: a byte is accepted at a rising edge where in_valid && in_ready. din and parity are latched into a shift register and a parity register. The FSM moves to START.
- in_valid without in_ready has no effect. din/parity may change freely outside the handshake cycle.
- Bit timer counts 0..CLKS_PER_BIT-1. Width is $clog2(CLKS_PER_BIT). Each state bit lasts exactly CLKS_PER_BIT cycles.
- START: tx=0. When the timer wraps, go to DATA with bit index 0.
- DATA: tx=shift[0]. On each timer wrap, shift right and increment the 3-bit index. After index 7 wraps, go to PARITY.
- PARITY: tx=latched parity bit, transmitted as received.
- STOP: tx=1. On the timer wrap, pulse frame_done and go to IDLE.
- tx is driven from a register, so it is glitch-free.
- Outputs in reset: tx=1, in_ready=1, busy=0, frame_done=0, par_err=0. The FSM resets to IDLE, and the timer, index and shift register reset to 0.
- Reset mid-frame: the frame is abandoned immediately. tx goes to 1 asynchronously. No frame_done is issued.
- No input buffering: bytes offered while busy stall until in_ready returns.

## Timing
- Handshake at edge N: tx=0 from cycle N+1.
- Frame length is 11*CLKS_PER_BIT cycles: cycles N+1 .. N+11*CLKS_PER_BIT.
- frame_done is high during cycle N+11*CLKS_PER_BIT.
- in_ready is high from cycle N+11*CLKS_PER_BIT+1.
- Back-to-back frames: if in_valid is held high, the next handshake occurs in the first IDLE cycle. There is exactly one idle tx=1 cycle between consecutive stop and start bits.
- busy is the complement of in_ready in every cycle.
- Data bit k (k=0..7) occupies cycles N+1+(k+1)*CLKS_PER_BIT .. N+(k+2)*CLKS_PER_BIT.

## Configuration
- Macro: PARITY_CHECK_EN.
- Defined:
  - On handshake, the block computes ^din and compares it with parity.
  - par_err is registered. It is set from cycle N+1 on a mismatch and held until the next handshake or reset.
  - On the next handshake, par_err is reloaded with that byte's comparison result.
  - The transmitted parity bit is still the received parity input, uncorrected.
- Not defined: no checker logic is built, and par_err is tied to 0.

## Test plan
- Reset state: hold rst=1 for 3 cycles, release -> tx=1, in_ready=1, busy=0, frame_done=0, par_err=0.
- Single frame: CLKS_PER_BIT=4, din=8'hA5, parity=0, one-cycle in_valid.
  - tx sequence in 4-cycle bits: 0, 1,0,1,0,0,1,0,1, 0, 1.
  - frame_done pulses once at cycle 44 after the handshake.
  - in_ready returns at cycle 45.
- Back-to-back frames: in_valid held high with 8'h00/0 then 8'hFF/0.
  - Two 44-cycle frames are sent, separated by exactly one tx=1 idle cycle.
  - The second frame's data bits are all 1.
- Stall: assert in_valid with 8'h3C while busy -> in_ready=0, no corruption of the current frame, 8'h3C is accepted in the first IDLE cycle.
- Reset mid-frame: assert rst during data bit 3 -> tx=1 within the same cycle, no frame_done, the FSM restarts in IDLE after release.
- PARITY_CHECK_EN defined: send din=8'h01 with parity=0.
  - par_err=1 from the cycle after the handshake; the transmitted parity bit is 0.
  - A following 8'h03/0 frame clears par_err.
  - Without the macro, par_err stays 0 throughout.
